// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the multi-channel byte-serial memory arbiter.
// Per-channel fields are packed [NUM_CH-1:0][...] so channel i occupies slice i.
interface mem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
);
  logic [NUM_CH-1:0]             req;
  logic [NUM_CH-1:0]             we;
  logic [NUM_CH-1:0][1:0]        size;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr;
  logic [NUM_CH-1:0][31:0]       wdata;
  logic [NUM_CH-1:0]             clr;
  logic [NUM_CH-1:0]             done;
  logic [31:0]                   rdata;
  logic                          busy;
  logic [7:0]                    mem_din;
  logic [7:0]                    mem_dout;
  logic [31:0]                   mem_a;
  logic                          mem_wr;

  modport master (
    output req, we, size, addr, wdata, clr, mem_din,
    input  done, rdata, busy, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  req, we, size, addr, wdata, clr, mem_din,
    output done, rdata, busy, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_CH requesters onto an 8-bit RAM bus, serialising 1/2/4-byte
// reads and writes; fixed-priority or round-robin grant, read abort, rdy_in pause.
module mem_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  mem_arbiter_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t             state;
  logic [CH_W-1:0]    ch, last_grant, gnt_ch, idx;
  logic               gnt_vld;
  logic [NUM_CH-1:0]  elig;
  logic [2:0]         n, iss, iss_nxt;
  logic [ADDR_W-1:0]  base, a_nxt;
  logic [31:0]        wbuf, rbuf, rmerge;
  logic               cap_vld;
  logic [1:0]         cap_idx;
  logic [NUM_CH-1:0]  done_q;
  logic [31:0]        rdata_q, a_q;
  logic               busy_q, wr_q;
  logic [7:0]         dout_q;

  function automatic logic [2:0] nbytes(input logic [1:0] s);
    case (s)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  always_comb begin
    elig    = bus.req & ~bus.clr;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == 1) idx = CH_W'((int'(last_grant) + 1 + k) % NUM_CH);
      else               idx = CH_W'(k);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx;
      end
    end
  end

  // iss indexes the byte currently on the bus; iss == n means none is shown.
  assign iss_nxt = iss + 3'd1;
  assign a_nxt   = base + ADDR_W'(iss_nxt);

  // Byte whose address was accepted last cycle lands this cycle, paused or not.
  always_comb begin
    rmerge = rbuf;
    if (cap_vld) rmerge[{cap_idx, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      ch         <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      n          <= '0;
      iss        <= '0;
      base       <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      dout_q     <= '0;
      a_q        <= '0;
    end else begin
      done_q  <= '0;
      rdata_q <= '0;
      case (state)
        IDLE: begin
          if (rdy_in && gnt_vld) begin
            ch         <= gnt_ch;
            last_grant <= gnt_ch;
            n          <= nbytes(bus.size[gnt_ch]);
            base       <= bus.addr[gnt_ch];
            wbuf       <= bus.wdata[gnt_ch];
            rbuf       <= '0;
            cap_vld    <= 1'b0;
            iss        <= '0;
            busy_q     <= 1'b1;
            a_q        <= 32'(bus.addr[gnt_ch]);
            if (bus.we[gnt_ch]) begin
              state  <= WR;
              wr_q   <= 1'b1;
              dout_q <= bus.wdata[gnt_ch][7:0];
            end else begin
              state  <= RD;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        RD: begin
          if (bus.clr[ch]) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            a_q     <= '0;
            cap_vld <= 1'b0;
          end else begin
            rbuf <= rmerge;
            if (rdy_in) begin
              if (iss != n) begin
                cap_vld <= 1'b1;
                cap_idx <= iss[1:0];
                iss     <= iss_nxt;
                a_q     <= (iss_nxt != n) ? 32'(a_nxt) : 32'd0;
              end else begin
                cap_vld    <= 1'b0;
                done_q[ch] <= 1'b1;
                rdata_q    <= rmerge;
                state      <= IDLE;
              end
            end else begin
              cap_vld <= 1'b0;
            end
          end
        end
        WR: begin
          if (rdy_in) begin
            if (iss_nxt != n) begin
              iss    <= iss_nxt;
              a_q    <= 32'(a_nxt);
              dout_q <= wbuf[{iss_nxt[1:0], 3'b000} +: 8];
            end else begin
              done_q[ch] <= 1'b1;
              state      <= IDLE;
              wr_q       <= 1'b0;
              a_q        <= '0;
              dout_q     <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.mem_a    = a_q;
  assign bus.mem_dout = dout_q;
  assign bus.mem_wr   = wr_q & rdy_in;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter share one stimulus
// stream and one synchronous-read RAM model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n0, n1;
  logic [1:0]  g0 [4];
  logic [1:0]  g1 [4];
  logic [31:0] d0 [4];
  logic [31:0] d1 [4];
  logic [31:0] wrap_a [4];
  logic [7:0]  ram [0:262143];

  mem_arbiter_if #(.NUM_CH(2), .ADDR_W(32)) b0 ();
  mem_arbiter_if #(.NUM_CH(2), .ADDR_W(32)) b1 ();

  mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .ARB_MODE(0)) dut_fp (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(b0));
  mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .ARB_MODE(1)) dut_rr (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(b1));

  always #5 clk = ~clk;

  assign b1.req   = b0.req;
  assign b1.we    = b0.we;
  assign b1.size  = b0.size;
  assign b1.addr  = b0.addr;
  assign b1.wdata = b0.wdata;
  assign b1.clr   = b0.clr;

  always @(posedge clk) begin
    b0.mem_din <= ram[b0.mem_a[17:0]];
    b1.mem_din <= ram[b1.mem_a[17:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},  32'(b0.done), 32'd0);
    chk({tag, "_rdata"}, b0.rdata,     32'd0);
    chk({tag, "_busy"},  32'(b0.busy), 32'd0);
    chk({tag, "_mem_a"}, b0.mem_a,     32'd0);
    chk({tag, "_wr"},    32'(b0.mem_wr), 32'd0);
    chk({tag, "_dout"},  32'(b0.mem_dout), 32'd0);
  endtask

  task automatic issue(input logic c, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    b0.req[c]   = 1'b1;
    b0.we[c]    = w;
    b0.size[c]  = sz;
    b0.addr[c]  = a;
    b0.wdata[c] = wd;
  endtask

  initial begin
    b0.req = '0; b0.we = '0; b0.size = '0; b0.addr = '0; b0.wdata = '0; b0.clr = '0;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h00100] = 8'h11; ram[18'h00101] = 8'h22;
    ram[18'h00102] = 8'h33; ram[18'h00103] = 8'h44;
    ram[18'h3FFFE] = 8'hA1; ram[18'h3FFFF] = 8'hA2;
    ram[18'h00000] = 8'hA3; ram[18'h00001] = 8'hA4;
    ram[18'h00010] = 8'h5A; ram[18'h00011] = 8'hA5;
    wrap_a[0] = 32'hFFFF_FFFE; wrap_a[1] = 32'hFFFF_FFFF;
    wrap_a[2] = 32'h0000_0000; wrap_a[3] = 32'h0000_0001;

    tick(); tick();
    chk_zero("reset");
    chk("reset_rr_done", 32'(b1.done), 32'd0);

    // 4-byte read on ch0
    rst = 1'b0;
    issue(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rd4_addr", b0.mem_a, 32'h100 + 32'(k));
      chk("rd4_wr", 32'(b0.mem_wr), 32'd0);
    end
    chk("rd4_busy", 32'(b0.busy), 32'd1);
    tick();
    chk("rd4_no_early_done", 32'(b0.done), 32'd0);
    tick();
    chk("rd4_done", 32'(b0.done), 32'd1);
    chk("rd4_rdata", b0.rdata, 32'h44332211);
    chk("rd4_rr_rdata", b1.rdata, 32'h44332211);
    b0.req[0] = 1'b0;
    tick();
    chk("rd4_busy_after", 32'(b0.busy), 32'd0);

    // 2-byte write on ch1
    issue(1'b1, 1'b1, 2'd1, 32'h200, 32'h0000BEEF);
    tick();
    chk("wr2_wr0", 32'(b0.mem_wr), 32'd1);
    chk("wr2_a0", b0.mem_a, 32'h200);
    chk("wr2_d0", 32'(b0.mem_dout), 32'hEF);
    tick();
    chk("wr2_wr1", 32'(b0.mem_wr), 32'd1);
    chk("wr2_a1", b0.mem_a, 32'h201);
    chk("wr2_d1", 32'(b0.mem_dout), 32'hBE);
    tick();
    chk("wr2_done", 32'(b0.done), 32'd2);
    chk("wr2_wr_off", 32'(b0.mem_wr), 32'd0);
    b0.req[1] = 1'b0;
    tick();
    chk("wr2_busy_after", 32'(b0.busy), 32'd0);

    // both channels requesting 1-byte reads continuously
    issue(1'b0, 1'b0, 2'd0, 32'h10, 32'h0);
    issue(1'b1, 1'b0, 2'd0, 32'h11, 32'h0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin g0[i] = '0; g1[i] = '0; d0[i] = '0; d1[i] = '0; end
    for (int t = 0; t < 40 && (n0 < 4 || n1 < 4); t++) begin
      tick();
      if (b0.done != 2'b00 && n0 < 4) begin g0[n0] = b0.done; d0[n0] = b0.rdata; n0++; end
      if (b1.done != 2'b00 && n1 < 4) begin g1[n1] = b1.done; d1[n1] = b1.rdata; n1++; end
      if (n0 == 4 && n1 == 4) b0.req = '0;
    end
    b0.req = '0;
    chk("fp_count", 32'(n0), 32'd4);
    chk("rr_count", 32'(n1), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("fp_grant", 32'(g0[i]), 32'd1);
      chk("fp_rdata", d0[i], 32'h5A);
      chk("rr_grant", 32'(g1[i]), (i % 2 == 1) ? 32'd2 : 32'd1);
      chk("rr_rdata", d1[i], (i % 2 == 1) ? 32'hA5 : 32'h5A);
    end
    tick();
    chk("arb_idle_fp", 32'(b0.busy), 32'd0);
    chk("arb_idle_rr", 32'(b1.busy), 32'd0);

    // 4-byte read paused for three cycles from cycle 1
    issue(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    tick();
    chk("pause_a0", b0.mem_a, 32'h100);
    tick();
    chk("pause_a1", b0.mem_a, 32'h101);
    rdy = 1'b0;
    tick();
    chk("pause_hold_a", b0.mem_a, 32'h101);
    chk("pause_wr", 32'(b0.mem_wr), 32'd0);
    tick();
    chk("pause_hold_done", 32'(b0.done), 32'd0);
    tick();
    chk("pause_hold_a2", b0.mem_a, 32'h101);
    rdy = 1'b1;
    tick();
    chk("pause_a2", b0.mem_a, 32'h102);
    tick();
    chk("pause_a3", b0.mem_a, 32'h103);
    tick();
    chk("pause_no_done7", 32'(b0.done), 32'd0);
    tick();
    chk("pause_done8", 32'(b0.done), 32'd1);
    chk("pause_rdata", b0.rdata, 32'h44332211);
    b0.req[0] = 1'b0;
    tick();

    // 1-byte write with rdy low in cycle 0: mem_wr masked, byte repeated
    issue(1'b0, 1'b1, 2'd0, 32'h400, 32'h77);
    tick();
    rdy = 1'b0;
    #1;
    chk("wpause_wr_masked", 32'(b0.mem_wr), 32'd0);
    chk("wpause_a", b0.mem_a, 32'h400);
    chk("wpause_d", 32'(b0.mem_dout), 32'h77);
    tick();
    rdy = 1'b1;
    #1;
    chk("wpause_wr_resume", 32'(b0.mem_wr), 32'd1);
    chk("wpause_no_done", 32'(b0.done), 32'd0);
    tick();
    chk("wpause_done", 32'(b0.done), 32'd1);
    b0.req[0] = 1'b0;
    tick();

    // clr on the granted read; pending ch1 read follows
    issue(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    issue(1'b1, 1'b0, 2'd0, 32'h11, 32'h0);
    tick();
    chk("abort_a0", b0.mem_a, 32'h100);
    tick(); tick();
    b0.clr[0] = 1'b1;
    tick();
    b0.clr[0] = 1'b0;
    b0.req[0] = 1'b0;
    chk("abort_busy", 32'(b0.busy), 32'd0);
    chk("abort_done", 32'(b0.done), 32'd0);
    chk("abort_a", b0.mem_a, 32'd0);
    tick();
    chk("abort_ch1_busy", 32'(b0.busy), 32'd1);
    chk("abort_ch1_a", b0.mem_a, 32'h11);
    tick();
    chk("abort_ch1_nodone", 32'(b0.done), 32'd0);
    tick();
    chk("abort_ch1_done", 32'(b0.done), 32'd2);
    chk("abort_ch1_rdata", b0.rdata, 32'hA5);
    b0.req[1] = 1'b0;
    tick();

    // address wrap at the top of the space
    issue(1'b0, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wrap_addr", b0.mem_a, wrap_a[k]);
    end
    tick();
    tick();
    chk("wrap_done", 32'(b0.done), 32'd1);
    chk("wrap_rdata", b0.rdata, 32'hA4A3A2A1);
    b0.req[0] = 1'b0;
    tick();

    // reset in the middle of a 4-byte write
    issue(1'b1, 1'b1, 2'd2, 32'h500, 32'hDEADBEEF);
    tick();
    chk("rstw_wr", 32'(b0.mem_wr), 32'd1);
    chk("rstw_d0", 32'(b0.mem_dout), 32'hEF);
    tick();
    chk("rstw_d1", 32'(b0.mem_dout), 32'hBE);
    rst = 1'b1;
    tick();
    chk_zero("rstw");
    rst = 1'b0;
    b0.req[1] = 1'b0;
    tick(); tick();
    chk("rstw_no_done", 32'(b0.done), 32'd0);
    chk("rstw_idle", 32'(b0.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
